// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
//   Shared definitions for the UART blocks: oversampling constants and the
//   receiver state encoding.
//
//   The PARITY state is always part of the enum so that state encodings stay
//   identical whether or not UART_RX_PARITY_EN is defined.
// -----------------------------------------------------------------------------
package uart_pkg;

    // Oversample ticks per bit period.
    localparam int OVS       = 16;
    // Tick index at the middle of the start bit.
    localparam int START_MID = 7;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state;

endpackage : uart_pkg

// File: rtl/sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
//   Two-flop synchronizer that brings an asynchronous signal into the clk
//   domain. Output latency is two clk cycles.
//
//   Parameters:
//     WIDTH    - number of independent bits synchronized
//     RST_VAL  - value both stages take while reset is asserted
//
//   Ports:
//     clk    in   system clock
//     rst_n  in   synchronous active-low reset
//     d      in   asynchronous input
//     q      out  synchronized output
// -----------------------------------------------------------------------------
module sync_2ff #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // NOTE: reset is sampled on the clock edge (synchronous), so it lives
    // inside the clocked process rather than in the sensitivity list.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: non-blocking assignments make both stages sample their
            // inputs from before the edge, which is what forms the two-stage chain.
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule : sync_2ff

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
//   UART receive deserializer. Uses a 16x oversample tick to find the middle
//   of the start bit, then samples each data bit (LSB first), an optional
//   parity bit and the stop bit at their bit centres.
//
//   Optional feature: define UART_RX_PARITY_EN to add a parity bit between
//   the data and the stop bit, with the parity_odd input and parity_err output.
//
//   Parameters:
//     DBIT     - data bits per frame (5..9)
//     SB_TICK  - stop-bit length in oversample ticks (16/24/32)
//
//   Ports:
//     clk           in   system clock
//     rst_n         in   synchronous active-low reset
//     tick          in   16x oversample strobe, 1 clk wide
//     rx            in   asynchronous serial line, idle high
//     parity_odd    in   (UART_RX_PARITY_EN) 1 = odd parity, 0 = even parity
//     parity_err    out  (UART_RX_PARITY_EN) pulse with rx_done_tick on parity mismatch
//     dout          out  receive shift register; capture it on rx_done_tick
//     rx_done_tick  out  1-cycle pulse: frame completed with a valid stop bit
//     frame_err     out  1-cycle pulse: stop bit sampled low
// -----------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            tick,
    input  logic            rx,
`ifdef UART_RX_PARITY_EN
    input  logic            parity_odd,
    output logic            parity_err,
`endif
    output logic [DBIT-1:0] dout,
    output logic            rx_done_tick,
    output logic            frame_err
);

    // The tick counter must reach both OVS-1 and SB_TICK-1.
    localparam int S_W = (SB_TICK > OVS) ? $clog2(SB_TICK) : $clog2(OVS);
    localparam int N_W = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [S_W-1:0] S_START_MID = S_W'(START_MID);
    localparam logic [S_W-1:0] S_BIT_END   = S_W'(OVS - 1);
    localparam logic [S_W-1:0] S_STOP_END  = S_W'(SB_TICK - 1);
    localparam logic [N_W-1:0] N_LAST      = N_W'(DBIT - 1);

    rx_state         state_q, state_d;
    logic [S_W-1:0]  s_q, s_d;
    logic [N_W-1:0]  n_q, n_d;
    logic [DBIT-1:0] b_q, b_d;
`ifdef UART_RX_PARITY_EN
    logic            p_q, p_d;
`endif

    logic            rx_s;
    logic            stop_end;

    sync_2ff #(
        .WIDTH   (1),
        .RST_VAL (1'b1)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rx_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
`ifdef UART_RX_PARITY_EN
            p_q     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
`ifdef UART_RX_PARITY_EN
            p_q     <= p_d;
`endif
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: every variable gets a default before the case statement, so no
        // path leaves it unassigned and no latch is inferred.
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        b_d     = b_q;
`ifdef UART_RX_PARITY_EN
        p_d     = p_q;
`endif

        unique case (state_q)
            // A falling edge starts the frame without waiting for a tick.
            IDLE: begin
                if (!rx_s) begin
                    state_d = START;
                    s_d     = '0;
                end
            end

            // A line that is high again at mid start bit was a glitch.
            START: begin
                if (tick) begin
                    if (s_q == S_START_MID) begin
                        if (!rx_s) begin
                            state_d = DATA;
                            s_d     = '0;
                            n_d     = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end

            // Sampling happens one full bit period after the previous centre.
            // Shifting right places the first bit received in bit 0.
            DATA: begin
                if (tick) begin
                    if (s_q == S_BIT_END) begin
                        s_d = '0;
                        b_d = {rx_s, b_q[DBIT-1:1]};
                        if (n_q == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = STOP;
`endif
                        end else begin
                            n_d = n_q + 1'b1;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end

            PARITY: begin
`ifdef UART_RX_PARITY_EN
                if (tick) begin
                    if (s_q == S_BIT_END) begin
                        s_d     = '0;
                        p_d     = rx_s;
                        state_d = STOP;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
`else
                state_d = IDLE;
`endif
            end

            STOP: begin
                if (tick) begin
                    if (s_q == S_STOP_END) begin
                        state_d = IDLE;
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    assign stop_end = (state_q == STOP) && tick && (s_q == S_STOP_END);

    // Output logic: the pulses are decoded from the cycle that completes
    // STOP, so each is high for exactly one clk and never together.
    always_comb begin
        rx_done_tick = 1'b0;
        frame_err    = 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_err   = 1'b0;
`endif
        if (stop_end) begin
            if (rx_s) begin
                rx_done_tick = 1'b1;
`ifdef UART_RX_PARITY_EN
                // Data plus parity must have odd weight for odd parity and
                // even weight for even parity.
                parity_err   = ((^b_q) ^ p_q) != parity_odd;
`endif
            end else begin
                frame_err = 1'b1;
            end
        end
    end

    assign dout = b_q;

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
//   Self-checking bench for uart_rx (DBIT=8, SB_TICK=16). tick comes from a
//   divide-by-4 counter, so one bit period is 64 clk. Each frame the bench
//   sends queues its expected pulse, and a monitor compares every pulse the
//   DUT produces against the head of that queue.
// -----------------------------------------------------------------------------
module tb_uart_rx;

    localparam int DBIT    = 8;
    localparam int BIT_CLK = 64;

    typedef struct {
        logic       is_err;
        logic [7:0] data;
        logic       perr;
    } exp_t;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b0;
    logic            rx    = 1'b1;
    logic            tick;
    logic [1:0]      tick_cnt = 2'd0;
    logic [DBIT-1:0] dout;
    logic            rx_done_tick;
    logic            frame_err;
`ifdef UART_RX_PARITY_EN
    logic            parity_odd = 1'b0;
    logic            parity_err;
`endif

    exp_t sb_q[$];
    int   checks    = 0;
    int   errors    = 0;
    int   pulse_cnt = 0;

    always #5 clk = ~clk;

    // Baud generator with M=4: one tick every fourth clk.
    always @(posedge clk) tick_cnt <= tick_cnt + 2'd1;
    assign tick = (tick_cnt == 2'd3);

    uart_rx #(
        .DBIT    (DBIT),
        .SB_TICK (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tick         (tick),
        .rx           (rx),
`ifdef UART_RX_PARITY_EN
        .parity_odd   (parity_odd),
        .parity_err   (parity_err),
`endif
        .dout         (dout),
        .rx_done_tick (rx_done_tick),
        .frame_err    (frame_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Holds rx at v for ncyc clocks; leaves the caller 1 time unit after an edge.
    task automatic drive(input logic v, input int ncyc);
        rx = v;
        repeat (ncyc) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop_bit, input int stop_clk,
                              input logic par_bit, input logic exp_perr);
        exp_t e;
        e.is_err = ~stop_bit;
        e.data   = data;
        e.perr   = exp_perr;
        sb_q.push_back(e);
        drive(1'b0, BIT_CLK);
        for (int i = 0; i < DBIT; i++) drive(data[i], BIT_CLK);
`ifdef UART_RX_PARITY_EN
        drive(par_bit, BIT_CLK);
`endif
        drive(stop_bit, stop_clk);
        rx = 1'b1;
    endtask

    // Valid frame with correct even parity (parity_odd stays 0).
    task automatic send_ok(input logic [7:0] data);
        send_frame(data, 1'b1, BIT_CLK, ^data, 1'b0);
    endtask

    // Monitor: every pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rx_done_tick === 1'b1 || frame_err === 1'b1) begin
            pulse_cnt++;
            if (sb_q.size() == 0) begin
                check("unexpected pulse {done,ferr}", 32'({rx_done_tick, frame_err}), 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("pulse kind {done,ferr}", 32'({rx_done_tick, frame_err}),
                      e.is_err ? 32'd1 : 32'd2);
                if (!e.is_err) begin
                    check("dout at done", 32'(dout), 32'(e.data));
`ifdef UART_RX_PARITY_EN
                    check("parity_err at done", 32'(parity_err), 32'(e.perr));
`endif
                end
            end
        end
    end

    initial begin
        int         saved;
        logic [7:0] d81;
        d81 = 8'h81;

        // Reset state.
        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset dout", 32'(dout), 32'd0);
        check("reset rx_done_tick", 32'(rx_done_tick), 32'd0);
        check("reset frame_err", 32'(frame_err), 32'd0);
        rst_n = 1'b1;
        drive(1'b1, 2 * BIT_CLK);

        // Plain 8N1 frame.
        send_ok(8'hA5);
        drive(1'b1, BIT_CLK);

        // Start glitch of 3 ticks.
        saved = pulse_cnt;
        drive(1'b0, 12);
        drive(1'b1, 3 * BIT_CLK);
        check("glitch gives no pulse", 32'(pulse_cnt), 32'(saved));

        // Stop bit low long enough to be sampled, then a good frame.
        send_frame(8'h3C, 1'b0, 40, ^8'h3C, 1'b0);
        drive(1'b1, 2 * BIT_CLK);
        send_ok(8'h55);
        drive(1'b1, BIT_CLK);

        // Back-to-back frames with no idle gap.
        send_ok(8'h00);
        send_ok(8'hFF);
        drive(1'b1, BIT_CLK);

        // Reset during data bit 4 of 0x81 discards the frame.
        drive(1'b0, BIT_CLK);
        for (int i = 0; i < 4; i++) drive(d81[i], BIT_CLK);
        drive(d81[4], 20);
        saved = pulse_cnt;
        rst_n = 1'b0;
        rx    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("dout after mid-frame reset", 32'(dout), 32'd0);
        rst_n = 1'b1;
        drive(1'b1, 4 * BIT_CLK);
        check("mid-frame reset gives no pulse", 32'(pulse_cnt), 32'(saved));
        send_ok(8'h81);
        drive(1'b1, BIT_CLK);

`ifdef UART_RX_PARITY_EN
        // Even parity: 0x07 has three ones, so the correct parity bit is 1.
        send_frame(8'h07, 1'b1, BIT_CLK, 1'b1, 1'b0);
        drive(1'b1, BIT_CLK);
        send_frame(8'h07, 1'b1, BIT_CLK, 1'b0, 1'b1);
        drive(1'b1, BIT_CLK);
`endif

        for (int i = 0; i < 2000 && sb_q.size() != 0; i++) @(posedge clk);
        check("all expected pulses seen", 32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        checks++;
        $display("FAIL watchdog: time limit reached, pending=%0d required=0", sb_q.size());
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_uart_rx
